pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives PC/IF-ID
//  freeze, ID/EX and IF/ID flush, and a global EXE/MEM/WB freeze.
//  Sources: RAW hazards between ID and EXE/MEM, taken branches resolved in EXE,
//  and multicycle SRAM accesses in MEM (ready handshake, timeout).
//  Sits beside the stage registers; its id_flush feeds the ID/EX register's flush.
// PARAMETERS
//  REG_ADDR_W   5    register-index width
//  FWD_EN       0    1 = forwarding present: only EXE load-use creates a hazard
//  MEM_TIMEOUT  255  max wait cycles in MEM_WAIT before ERROR (>=1)
//  CNT_W        8    wait-counter width; must hold MEM_TIMEOUT
// PORTS
//  clk            in   1     clock, all state on posedge
//  rst            in   1     synchronous reset, ACTIVE-LOW
//  id_valid       in   1     ID holds a real instruction
//  id_src1        in   RAW   ID source reg 1 (RAW = REG_ADDR_W)
//  id_src2        in   RAW   ID source reg 2
//  id_two_src     in   1     id_src2 is really read
//  exe_dest       in   RAW   EXE destination
//  exe_wb_en      in   1     EXE writes back
//  exe_mem_r_en   in   1     EXE is a load
//  exe_br_taken   in   1     branch taken in EXE
//  mem_dest       in   RAW   MEM destination
//  mem_wb_en      in   1     MEM writes back
//  mem_stage_req  in   1     MEM instruction is a load/store
//  mem_ready      in   1     SRAM access complete this cycle
//  pc_freeze      out  1     hold PC
//  if_freeze      out  1     hold IF/ID register
//  if_flush       out  1     clear IF/ID register
//  id_flush       out  1     clear ID/EX register (bubble)
//  pipe_freeze    out  1     hold ID/EX, EXE/MEM, MEM/WB
//  mem_start      out  1     1-cycle pulse: new SRAM access begins
//  timeout_err    out  1     sticky: SRAM never answered
//  stall_cycles   out  16    saturating count of cycles with any freeze
//  state          out  2     current FSM state (debug)
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=RUN, wait_cnt=0, stall_cycles=0,
//   timeout_err=0, mem_start seen-flag=0; while rst==0 all control outputs
//   are 0. Reset mid-MEM_WAIT/ERROR aborts to RUN next edge.
//  Hazard (comb): h = id_valid & (hit(exe) | hit(mem)), where hit(s) =
//   s_wb_en & s_dest!=0 & (s_dest==id_src1 | id_two_src & s_dest==id_src2).
//   FWD_EN=1: h = id_valid & exe_mem_r_en & hit(exe); MEM never counts.
//  States: RUN=0, MEM_WAIT=1, ERROR=2. Outputs are comb from state+inputs.
//  RUN, priority top-down:
//   1 mem_stage_req & !mem_ready: all four freezes=1, flushes=0;
//     mem_start=1 (first cycle only); next=MEM_WAIT, wait_cnt=1.
//   2 mem_stage_req & mem_ready: single-cycle access, mem_start=1,
//     no freeze; then apply 3/4 normally this cycle.
//   3 exe_br_taken: if_flush=1, id_flush=1, no freezes (branch beats h;
//     the dependent instruction is squashed).
//   4 h: pc_freeze=if_freeze=1, id_flush=1, pipe_freeze=0.
//   5 else all 0.
//  MEM_WAIT: all freezes=1, flushes=0, mem_start=0. Held exe_br_taken/h
//   are deferred. mem_ready=1 -> freezes drop THIS cycle, rules 3/4 apply
//   to current inputs, next=RUN, wait_cnt=0. Else wait_cnt++;
//   wait_cnt==MEM_TIMEOUT w/o ready -> next=ERROR, timeout_err<=1.
//  ERROR: all freezes=1 until reset; mem_ready ignored.
//  mem_ready with mem_stage_req=0 in RUN: ignored.
//  stall_cycles: +1 each cycle any freeze=1, saturates at 16'hFFFF.
// STRUCTURE
//  pipe_ctrl_pkg: state encodings, REG_ZERO, default widths.
//  Sub-module hazard_detect (comb RAW compare, FWD_EN param) instantiated once;
//  FSM, wait counter, stall counter in top.
// TESTING
//  T1 ID add r3<-r1,r2; EXE dest r1 wb_en -> 1 cycle pc/if_freeze=1,
//     id_flush=1; FWD_EN=1 same case -> no stall; EXE load r1 -> stall.
//  T2 exe_dest=0 with id_src1=0 -> no hazard, all outputs 0.
//  T3 mem_stage_req=1, mem_ready after 3 cycles -> mem_start 1 pulse,
//     freezes 4 cycles total, state RUN after, stall_cycles=+4 (incl. start).
//  T4 MEM_WAIT with exe_br_taken=1 held -> no flush during wait; flush
//     pulses on ready cycle only.
//  T5 MEM_TIMEOUT=4, mem_ready never -> ERROR after 4 wait cycles,
//     timeout_err=1 sticky; rst=0 one edge -> RUN, all counters 0.
//  T6 branch and hazard same cycle -> if_flush=id_flush=1, no freeze.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Purpose: shared constants and types for the pipeline stall/flush sequencer.
//   - FSM state encodings (RUN, MEM_WAIT, ERROR)
//   - REG_ZERO: the hard-wired zero register index, which never causes a RAW hazard
//   - default widths
//   - ctrl_t: the bundle of freeze/flush controls produced each cycle
package pipeline_hazard_ctrl_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CNT_W      = 8;
  localparam int STALL_W        = 16;
  localparam int REG_ZERO       = 0;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  typedef struct packed {
    logic pc_freeze;
    logic if_freeze;
    logic if_flush;
    logic id_flush;
    logic pipe_freeze;
  } ctrl_t;

  // Whole-pipeline hold: PC, IF/ID and the back end all frozen, nothing flushed.
  localparam ctrl_t CTRL_FREEZE_ALL = 5'b11001;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Purpose: groups the stage-status inputs and control outputs of the hazard
// sequencer.
//   - slave modport: used by the sequencer. It reads the ID/EXE/MEM status
//     and drives the freeze/flush/debug outputs.
//   - master modport: used by the pipeline side, with the directions reversed.
interface pipeline_hazard_ctrl_if
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_two_src;
  logic [REG_ADDR_W-1:0] exe_dest;
  logic                  exe_wb_en;
  logic                  exe_mem_r_en;
  logic                  exe_br_taken;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb_en;
  logic                  mem_stage_req;
  logic                  mem_ready;
  logic                  pc_freeze;
  logic                  if_freeze;
  logic                  if_flush;
  logic                  id_flush;
  logic                  pipe_freeze;
  logic                  mem_start;
  logic                  timeout_err;
  logic [STALL_W-1:0]    stall_cycles;
  logic [1:0]            state;

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src,
    input  exe_dest, exe_wb_en, exe_mem_r_en, exe_br_taken,
    input  mem_dest, mem_wb_en, mem_stage_req, mem_ready,
    output pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze,
    output mem_start, timeout_err, stall_cycles, state
  );

  modport master (
    output id_valid, id_src1, id_src2, id_two_src,
    output exe_dest, exe_wb_en, exe_mem_r_en, exe_br_taken,
    output mem_dest, mem_wb_en, mem_stage_req, mem_ready,
    input  pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze,
    input  mem_start, timeout_err, stall_cycles, state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Purpose: combinational RAW hazard check between the instruction in ID and
// the older instructions in EXE and MEM.
// Ports:
//   - inputs: ID source registers, plus EXE/MEM destination, write-back enable
//     and EXE load flag
//   - output: hazard
// FWD_EN:
//   - FWD_EN=1: forwarding covers every case except a load still in EXE, so
//     only that case raises hazard.
//   - FWD_EN=0: any pending write from EXE or MEM to a register that ID reads
//     raises hazard.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter bit FWD_EN     = 1'b0
) (
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  output logic                  hazard
);
  // Index 0 = EXE, index 1 = MEM.
  logic [REG_ADDR_W-1:0] dest  [2];
  logic [1:0]            wb_en;
  logic [1:0]            hit;

  assign dest[0] = exe_dest;
  assign dest[1] = mem_dest;
  assign wb_en   = {mem_wb_en, exe_wb_en};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stage_hit
    // Writes to the zero register are discarded, so they never conflict.
    assign hit[gi] = wb_en[gi] && (dest[gi] != REG_ADDR_W'(REG_ZERO)) &&
                     ((dest[gi] == id_src1) || (id_two_src && (dest[gi] == id_src2)));
  end

  assign hazard = FWD_EN ? (id_valid && exe_mem_r_en && hit[0])
                         : (id_valid && (hit[0] || hit[1]));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: central stall/flush sequencer for the 5-stage pipeline.
// Ports:
//   - clk: clock.
//   - rst: synchronous reset, active-low.
//   - bus: slave modport carrying the stage status in and the freeze/flush
//     controls, mem_start, timeout_err, stall_cycles and state out.
// Behaviour:
//   - In RUN, rule priority is: SRAM miss, then branch flush, then RAW stall.
//   - A multicycle SRAM access holds the whole pipe in MEM_WAIT.
//   - If the SRAM does not answer within MEM_TIMEOUT wait cycles, the FSM
//     parks in ERROR with the whole pipe frozen until reset.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter bit FWD_EN      = 1'b0,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_err_q, timeout_err_d;
  logic               hazard;
  ctrl_t              flow_ctrl;  // branch/RAW response for the current inputs
  ctrl_t              ctrl;
  logic               mem_start_c;
  logic               any_freeze;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_EN     (FWD_EN)
  ) u_hazard_detect (
    .id_valid     (bus.id_valid),
    .id_src1      (bus.id_src1),
    .id_src2      (bus.id_src2),
    .id_two_src   (bus.id_two_src),
    .exe_dest     (bus.exe_dest),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_r_en (bus.exe_mem_r_en),
    .mem_dest     (bus.mem_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .hazard       (hazard)
  );

  // A taken branch squashes the dependent instruction, so the flush wins and
  // no stall is needed.
  always_comb begin
    flow_ctrl = '0;
    if (bus.exe_br_taken) begin
      flow_ctrl.if_flush = 1'b1;
      flow_ctrl.id_flush = 1'b1;
    end else if (hazard) begin
      flow_ctrl.pc_freeze = 1'b1;
      flow_ctrl.if_freeze = 1'b1;
      flow_ctrl.id_flush  = 1'b1;
    end
  end

  always_comb begin
    ctrl          = '0;
    mem_start_c   = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_RUN: begin
        if (bus.mem_stage_req && !bus.mem_ready) begin
          ctrl        = CTRL_FREEZE_ALL;
          mem_start_c = 1'b1;
          state_d     = ST_MEM_WAIT;
          wait_cnt_d  = CNT_W'(1);
        end else begin
          // A single-cycle access still pulses mem_start; the pipe keeps flowing.
          mem_start_c = bus.mem_stage_req;
          ctrl        = flow_ctrl;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ready) begin
          // Freezes release on the ready cycle itself; any branch or RAW stall
          // held back during the wait takes effect now.
          ctrl       = flow_ctrl;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          ctrl = CTRL_FREEZE_ALL;
          if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
            state_d       = ST_ERROR;
            timeout_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ERROR: ctrl = CTRL_FREEZE_ALL;
      default:  state_d = ST_RUN;
    endcase
    if (!rst) begin
      ctrl        = '0;
      mem_start_c = 1'b0;
    end
  end

  assign any_freeze = ctrl.pc_freeze || ctrl.if_freeze || ctrl.pipe_freeze;
  assign stall_d    = (any_freeze && (stall_q != {STALL_W{1'b1}})) ? stall_q + 16'd1 : stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      stall_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_q       <= stall_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.pc_freeze    = ctrl.pc_freeze;
  assign bus.if_freeze    = ctrl.if_freeze;
  assign bus.if_flush     = ctrl.if_flush;
  assign bus.id_flush     = ctrl.id_flush;
  assign bus.pipe_freeze  = ctrl.pipe_freeze;
  assign bus.mem_start    = mem_start_c;
  assign bus.timeout_err  = timeout_err_q && rst;
  assign bus.stall_cycles = stall_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl.
// DUT instances:
//   - dut_a: FWD_EN=0, MEM_TIMEOUT=4. This instance sees the full stimulus.
//   - dut_b: FWD_EN=1. It gets the same hazard inputs, but its mem_stage_req
//     is tied low, so it only exercises the branch/RAW rules.
// Stimulus and checking:
//   - Each table row is one clock cycle. It holds the inputs, the expected
//     dut_a outputs and state, and the expected dut_b controls.
//   - Expected results are queued when a row is driven. They are popped and
//     compared on the following falling edge.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) ifa ();
  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) ifb ();

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b0), .MEM_TIMEOUT(4), .CNT_W(8)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b1), .MEM_TIMEOUT(255), .CNT_W(8)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  typedef struct {
    bit         rst_n;
    bit         idv;
    logic [4:0] s1;
    logic [4:0] s2;
    bit         two;
    logic [4:0] ed;
    bit         ewb;
    bit         eld;
    bit         br;
    logic [4:0] md;
    bit         mwb;
    bit         req;
    bit         rdy;
    logic [6:0] ea;  // {pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze, mem_start, timeout_err}
    logic [1:0] st;
    logic [3:0] eb;  // dut_b {pc_freeze, if_freeze, if_flush, id_flush}
  } vec_t;

  typedef struct {
    int          row;
    logic [6:0]  ea;
    logic [1:0]  st;
    logic [3:0]  eb;
    logic [15:0] stall;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t v(bit rn, bit idv, int s1, int s2, bit two, int ed, bit ewb, bit eld,
                             bit br, int md, bit mwb, bit req, bit rdy,
                             logic [6:0] ea, int st, logic [3:0] eb);
    vec_t r;
    r.rst_n = rn;  r.idv = idv; r.s1 = 5'(s1); r.s2 = 5'(s2); r.two = two;
    r.ed = 5'(ed); r.ewb = ewb; r.eld = eld;   r.br = br;
    r.md = 5'(md); r.mwb = mwb; r.req = req;   r.rdy = rdy;
    r.ea = ea;     r.st = 2'(st); r.eb = eb;
    return r;
  endfunction

  function automatic vec_t idle(bit rn, int st, logic [6:0] ea);
    return v(rn, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ea, st, 4'b0000);
  endfunction

  function automatic vec_t memc(bit req, bit rdy, int st, logic [6:0] ea);
    return v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, req, rdy, ea, st, 4'b0000);
  endfunction

  task automatic drive(input vec_t r);
    rst              = r.rst_n;
    ifa.id_valid     = r.idv;  ifb.id_valid     = r.idv;
    ifa.id_src1      = r.s1;   ifb.id_src1      = r.s1;
    ifa.id_src2      = r.s2;   ifb.id_src2      = r.s2;
    ifa.id_two_src   = r.two;  ifb.id_two_src   = r.two;
    ifa.exe_dest     = r.ed;   ifb.exe_dest     = r.ed;
    ifa.exe_wb_en    = r.ewb;  ifb.exe_wb_en    = r.ewb;
    ifa.exe_mem_r_en = r.eld;  ifb.exe_mem_r_en = r.eld;
    ifa.exe_br_taken = r.br;   ifb.exe_br_taken = r.br;
    ifa.mem_dest     = r.md;   ifb.mem_dest     = r.md;
    ifa.mem_wb_en    = r.mwb;  ifb.mem_wb_en    = r.mwb;
    ifa.mem_stage_req = r.req; ifb.mem_stage_req = 1'b0;
    ifa.mem_ready    = r.rdy;  ifb.mem_ready    = r.rdy;
  endtask

  task automatic check(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, exp);
    end
  endtask

  initial begin
    vec_t        r;
    exp_t        e;
    logic [15:0] exp_stall;
    logic [6:0]  act_a;
    logic [3:0]  act_b;

    drive(idle(0, 0, 7'b0));
    repeat (2) @(posedge clk);

    // Single-cycle vectors: hazard and branch rules with the FSM in RUN.
    tbl.push_back(v(0,1,1,2,1,1,1,1,0,0,0,0,0, 7'b0000000,0,4'b0000)); // reset gates hazard
    tbl.push_back(v(1,1,1,2,1,1,1,0,0,0,0,0,0, 7'b1101000,0,4'b0000)); // T1 EXE ALU dep
    tbl.push_back(v(1,1,1,2,1,1,1,1,0,0,0,0,0, 7'b1101000,0,4'b1101)); // T1 EXE load dep
    tbl.push_back(v(1,1,4,1,1,1,1,1,0,0,0,0,0, 7'b1101000,0,4'b1101)); // src2 match
    tbl.push_back(v(1,1,4,1,0,1,1,1,0,0,0,0,0, 7'b0000000,0,4'b0000)); // src2 not read
    tbl.push_back(v(1,1,5,2,1,0,0,0,0,5,1,0,0, 7'b1101000,0,4'b0000)); // MEM dep
    tbl.push_back(v(1,1,0,0,1,0,1,1,0,0,1,0,0, 7'b0000000,0,4'b0000)); // T2 r0
    tbl.push_back(v(1,0,1,2,1,1,1,1,0,0,0,0,0, 7'b0000000,0,4'b0000)); // ID bubble
    tbl.push_back(v(1,1,1,2,1,1,0,1,0,0,0,0,0, 7'b0000000,0,4'b0000)); // EXE no wb
    tbl.push_back(v(1,1,1,2,1,1,1,1,1,0,0,0,0, 7'b0011000,0,4'b0011)); // T6 branch+hazard
    tbl.push_back(memc(0,1,0, 7'b0000000));                            // stray ready
    tbl.push_back(memc(1,1,0, 7'b0000010));                            // 1-cycle access
    tbl.push_back(v(1,1,1,2,1,1,1,0,0,0,0,1,1, 7'b1101010,0,4'b0000)); // 1-cycle + hazard
    // T3: start cycle, three wait cycles, ready.
    tbl.push_back(memc(1,0,0, 7'b1100110));
    for (int i = 0; i < 3; i++) tbl.push_back(memc(1,0,1, 7'b1100100));
    tbl.push_back(memc(1,1,1, 7'b0000000));
    tbl.push_back(idle(1,0, 7'b0000000));
    // T4: held branch deferred until ready.
    tbl.push_back(v(1,1,1,2,1,1,1,1,1,0,0,1,0, 7'b1100110,0,4'b0011));
    tbl.push_back(v(1,1,1,2,1,1,1,1,1,0,0,1,0, 7'b1100100,1,4'b0011));
    tbl.push_back(v(1,1,1,2,1,1,1,1,1,0,0,1,1, 7'b0011000,1,4'b0011));
    tbl.push_back(idle(1,0, 7'b0000000));
    // Held RAW hazard applies on the ready cycle.
    tbl.push_back(v(1,1,1,2,1,1,1,0,0,0,0,1,0, 7'b1100110,0,4'b0000));
    tbl.push_back(v(1,1,1,2,1,1,1,0,0,0,0,1,1, 7'b1101000,1,4'b0000));
    tbl.push_back(idle(1,0, 7'b0000000));
    // T5: timeout after 4 wait cycles, sticky error, reset recovery.
    tbl.push_back(memc(1,0,0, 7'b1100110));
    for (int i = 0; i < 4; i++) tbl.push_back(memc(1,0,1, 7'b1100100));
    tbl.push_back(memc(1,1,2, 7'b1100101));
    tbl.push_back(idle(1,2, 7'b1100101));
    tbl.push_back(idle(0,2, 7'b0000000));
    tbl.push_back(idle(1,0, 7'b0000000));
    tbl.push_back(v(1,1,1,2,1,1,1,0,0,0,0,0,0, 7'b1101000,0,4'b0000));
    tbl.push_back(idle(1,0, 7'b0000000));

    exp_stall = 16'd0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      r = tbl[i];
      drive(r);
      e.row = i; e.ea = r.ea; e.st = r.st; e.eb = r.eb; e.stall = exp_stall;
      sb.push_back(e);
      if (!r.rst_n)                                exp_stall = 16'd0;
      else if (r.ea[6] || r.ea[5] || r.ea[2])      exp_stall = exp_stall + 16'd1;

      @(negedge clk);
      e = sb.pop_front();
      act_a = {ifa.pc_freeze, ifa.if_freeze, ifa.if_flush, ifa.id_flush,
               ifa.pipe_freeze, ifa.mem_start, ifa.timeout_err};
      act_b = {ifb.pc_freeze, ifb.if_freeze, ifb.if_flush, ifb.id_flush};
      $display("row %0d a_ctrl=%b state=%0d b_ctrl=%b stall=%0d", e.row, act_a, ifa.state, act_b,
               ifa.stall_cycles);
      check("a_ctrl", e.row, 16'(act_a), 16'(e.ea));
      check("a_state", e.row, 16'(ifa.state), 16'(e.st));
      check("b_ctrl", e.row, 16'(act_b), 16'(e.eb));
      check("stall_cycles", e.row, ifa.stall_cycles, e.stall);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
